pipe_ctrl: RTL

- Parametrised pipeline control unit for the RV32I core: per-stage stall-mask generation, redirect/flush sequencing for exceptions, mret and branch mispredicts, and trap-vector target computation.
- Generalises the combinational hazard logic:
  - stage count and vector count are parameters;
  - redirects are registered and flush is held for a programmable window;
  - a consecutive-stall counter with watchdog pulse is added.
- Sits beside the pipeline registers; drives every stage's stall bit and the global flush/new_pc.

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// master = pipe_ctrl (drives stall/flush/redirect), slave = pipeline side.
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 6,
    parameter int XLEN       = 32,
    parameter int CAUSE_W    = 5
);
    logic [NUM_STAGES-1:0] stallreq_i;
    logic                  except_valid_i;
    logic [CAUSE_W-1:0]    except_cause_i;
    logic                  mret_i;
    logic [XLEN-1:0]       mepc_i;
    logic [XLEN-1:0]       mtvec_i;
    logic                  branch_flag_i;
    logic [XLEN-1:0]       branch_tar_addr_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic                  flush_o;
    logic [XLEN-1:0]       new_pc_o;
    logic                  redirect_valid_o;
    logic [15:0]           stall_cnt_o;
    logic                  stall_timeout_o;

    modport master (
        input  stallreq_i, except_valid_i, except_cause_i, mret_i, mepc_i,
               mtvec_i, branch_flag_i, branch_tar_addr_i,
        output stall_o, flush_o, new_pc_o, redirect_valid_o, stall_cnt_o,
               stall_timeout_o
    );

    modport slave (
        output stallreq_i, except_valid_i, except_cause_i, mret_i, mepc_i,
               mtvec_i, branch_flag_i, branch_tar_addr_i,
        input  stall_o, flush_o, new_pc_o, redirect_valid_o, stall_cnt_o,
               stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall masks, registered redirect/flush sequencing
// for exceptions, mret and mispredicts, and a consecutive-stall watchdog.
module pipe_ctrl #(
    parameter int          NUM_STAGES     = 6,
    parameter int          XLEN           = 32,
    parameter int          CAUSE_W        = 5,
    parameter int unsigned NUM_VECTORS    = 16,
    parameter int          IF_STALL_DEPTH = 2,
    parameter int          FLUSH_LEN      = 1,
    parameter int unsigned STALL_TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus
);
    typedef enum logic {RUN, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]       new_pc_q, new_pc_d;
    logic                  redir_q, redir_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_STAGES-1:0] req_mask;
    logic [NUM_STAGES-1:0] stall;
    logic [XLEN-1:0]       trap_base, trap_tgt, target;
    logic                  take_exc, take_mret, take_br, accept;
    int                    hi_idx;
    logic                  any_req;

    // Requests from stage 0 (fetch) must also hold the stages up to IF_STALL_DEPTH.
    always_comb begin
        hi_idx  = 0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.stallreq_i[i]) begin
                hi_idx  = i;
                any_req = 1'b1;
            end
        end
        if (hi_idx == 0) hi_idx = IF_STALL_DEPTH;
        req_mask = '0;
        if (any_req) begin
            for (int i = 0; i < NUM_STAGES; i++) req_mask[i] = (i <= hi_idx);
        end
    end

    always_comb begin
        trap_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
        trap_tgt  = trap_base;
        if (bus.mtvec_i[1:0] == 2'b01 && 32'(bus.except_cause_i) < NUM_VECTORS)
            trap_tgt = trap_base + (XLEN'(bus.except_cause_i) << 2);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        redir_d     = 1'b0;

        take_exc  = bus.except_valid_i;
        take_mret = !bus.except_valid_i && bus.mret_i;
        // A branch resolving during a flush belongs to a squashed wrong-path instruction.
        take_br   = (state_q == RUN) && !bus.except_valid_i && !bus.mret_i && bus.branch_flag_i;
        accept    = take_exc || take_mret || take_br;

        if (take_exc)       target = trap_tgt;
        else if (take_mret) target = bus.mepc_i;
        else                target = bus.branch_tar_addr_i;

        if (accept) begin
            state_d     = FLUSH;
            flush_cnt_d = 4'(FLUSH_LEN - 1);
            new_pc_d    = target;
            redir_d     = 1'b1;
        end else if (state_q == FLUSH) begin
            if (flush_cnt_q == 4'd0) state_d = RUN;
            else                     flush_cnt_d = flush_cnt_q - 4'd1;
        end

        stall = (state_q == RUN && !accept && !rst) ? req_mask : '0;

        if (stall != '0)
            stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
        else
            stall_cnt_d = '0;

        timeout_d = (STALL_TIMEOUT != 0) && (32'(stall_cnt_d) == STALL_TIMEOUT) &&
                    (stall_cnt_d != stall_cnt_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            new_pc_q    <= '0;
            redir_q     <= 1'b0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            new_pc_q    <= new_pc_d;
            redir_q     <= redir_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.stall_o          = stall;
    assign bus.flush_o          = (state_q == FLUSH);
    assign bus.new_pc_o         = new_pc_q;
    assign bus.redirect_valid_o = redir_q;
    assign bus.stall_cnt_o      = stall_cnt_q;
    assign bus.stall_timeout_o  = timeout_q;
endmodule
